// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: unified-memory read port, hazard/redirect/interrupt inputs
// and the registered IF/ID bundle handed to decode.
interface fetch_stage_if;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       stall;
  logic       redirect_en;
  logic [7:0] redirect_pc;
  logic       int_sig;
  logic       if_valid;
  logic [7:0] if_instr;
  logic [7:0] if_imm;
  logic [7:0] if_pc_next;
  logic       if_int;
  logic [7:0] pc;

  modport master (
    output imem_addr, if_valid, if_instr, if_imm, if_pc_next, if_int, pc,
    input  imem_data, stall, redirect_en, redirect_pc, int_sig
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_imm, if_pc_next, if_int, pc,
    output imem_data, stall, redirect_en, redirect_pc, int_sig
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 8-bit pipelined CPU: owns the PC, loads the
// reset/interrupt vectors and assembles 1/2-byte instructions into IF/ID.
module fetch_stage #(
  parameter logic [3:0] TWO_BYTE_OP  = 4'hC,
  parameter logic [7:0] RST_VEC_ADDR = 8'h00,
  parameter logic [7:0] INT_VEC_ADDR = 8'h01,
  parameter logic [7:0] INT_BUBBLE   = 8'h00
) (
  input  logic          clk,
  input  logic          rstn,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {S_VEC, S_OP, S_IMM} state_t;

  state_t     state;
  logic       vec_sel;
  logic       int_pending;
  logic       int_sig_d;
  logic [7:0] pc_q;
  logic [7:0] hold;
  logic       valid_q;
  logic       int_q;
  logic [7:0] instr_q;
  logic [7:0] imm_q;
  logic [7:0] pc_next_q;
  logic       int_edge;
  logic [7:0] pc_inc;

  assign int_edge = bus.int_sig & ~int_sig_d;
  assign pc_inc   = pc_q + 8'd1;

  assign bus.imem_addr  = (state == S_VEC) ? (vec_sel ? INT_VEC_ADDR : RST_VEC_ADDR) : pc_q;
  assign bus.if_valid   = valid_q;
  assign bus.if_instr   = instr_q;
  assign bus.if_imm     = imm_q;
  assign bus.if_pc_next = pc_next_q;
  assign bus.if_int     = int_q;
  assign bus.pc         = pc_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_VEC;
      vec_sel     <= 1'b0;
      int_pending <= 1'b0;
      int_sig_d   <= 1'b0;
      pc_q        <= '0;
      hold        <= '0;
      valid_q     <= 1'b0;
      int_q       <= 1'b0;
      instr_q     <= '0;
      imm_q       <= '0;
      pc_next_q   <= '0;
    end else begin
      int_sig_d <= bus.int_sig;
      if (int_edge) int_pending <= 1'b1;

      unique case (state)
        S_VEC: begin
          valid_q <= 1'b0;
          state   <= S_OP;
          // A redirect only aborts the ISR vector load; the interrupt is re-armed.
          if (bus.redirect_en && vec_sel) begin
            pc_q        <= bus.redirect_pc;
            int_pending <= 1'b1;
          end else begin
            pc_q <= bus.imem_data;
          end
        end

        S_OP: begin
          if (bus.redirect_en) begin
            pc_q    <= bus.redirect_pc;
            valid_q <= 1'b0;
          end else if (!bus.stall) begin
            if (int_pending) begin
              valid_q     <= 1'b1;
              int_q       <= 1'b1;
              instr_q     <= INT_BUBBLE;
              imm_q       <= '0;
              pc_next_q   <= pc_q;
              int_pending <= int_edge;
              vec_sel     <= 1'b1;
              state       <= S_VEC;
            end else if (bus.imem_data[7:4] == TWO_BYTE_OP) begin
              hold    <= bus.imem_data;
              pc_q    <= pc_inc;
              valid_q <= 1'b0;
              state   <= S_IMM;
            end else begin
              instr_q   <= bus.imem_data;
              imm_q     <= '0;
              pc_next_q <= pc_inc;
              valid_q   <= 1'b1;
              int_q     <= 1'b0;
              pc_q      <= pc_inc;
            end
          end
        end

        S_IMM: begin
          if (bus.redirect_en) begin
            pc_q    <= bus.redirect_pc;
            valid_q <= 1'b0;
            state   <= S_OP;
          end else if (!bus.stall) begin
            instr_q   <= hold;
            imm_q     <= bus.imem_data;
            pc_next_q <= pc_inc;
            valid_q   <= 1'b1;
            int_q     <= 1'b0;
            pc_q      <= pc_inc;
            state     <= S_OP;
          end
        end

        default: state <= S_VEC;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/redirect/interrupt/reset traffic, checked against an instruction-level model.
module tb_fetch_stage;

  localparam logic [7:0] RST_VEC = 8'h00;
  localparam logic [7:0] INT_VEC = 8'h01;

  logic clk;
  logic rstn;
  logic [7:0] mem [256];
  int checks;
  int errors;

  fetch_stage_if bus();

  fetch_stage #(
    .TWO_BYTE_OP (4'hC),
    .RST_VEC_ADDR(8'h00),
    .INT_VEC_ADDR(8'h01),
    .INT_BUBBLE  (8'h00)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  assign bus.imem_data = mem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: "next fetch is a vector load", "opcode waiting for its
  // immediate", pending interrupt, plus the expected IF/ID bundle.
  bit         m_init;
  bit         m_vec;
  bit         m_vsel;
  bit         m_half;
  bit         m_pend;
  bit         m_sigd;
  logic [7:0] m_pc;
  logic [7:0] m_op;
  bit         e_valid;
  bit         e_int;
  logic [7:0] e_instr;
  logic [7:0] e_imm;
  logic [7:0] e_next;

  function automatic logic [7:0] model_addr();
    return m_vec ? (m_vsel ? INT_VEC : RST_VEC) : m_pc;
  endfunction

  task automatic emit(input logic [7:0] instr, input logic [7:0] imm);
    e_valid = 1'b1;
    e_int   = 1'b0;
    e_instr = instr;
    e_imm   = imm;
    e_next  = m_pc + 8'd1;
    m_pc    = m_pc + 8'd1;
  endtask

  task automatic model_clock(input bit r, input bit s, input bit re,
                             input logic [7:0] rp, input bit is);
    logic [7:0] d;
    bit edge_now;
    bit pend_next;
    if (!r) begin
      m_init = 1; m_vec = 1; m_vsel = 0; m_half = 0; m_pend = 0; m_sigd = 0;
      m_pc = '0; m_op = '0;
      e_valid = 0; e_int = 0; e_instr = '0; e_imm = '0; e_next = '0;
      return;
    end
    edge_now  = is && !m_sigd;
    m_sigd    = is;
    pend_next = m_pend || edge_now;
    d = mem[model_addr()];
    if (m_vec) begin
      e_valid = 0;
      m_vec   = 0;
      if (re && m_vsel) begin
        m_pc      = rp;
        pend_next = 1;
      end else begin
        m_pc = d;
      end
    end else if (re) begin
      m_pc    = rp;
      m_half  = 0;
      e_valid = 0;
    end else if (s) begin
      // frozen
    end else if (m_half) begin
      emit(m_op, d);
      m_half = 0;
    end else if (m_pend) begin
      e_valid   = 1;
      e_int     = 1;
      e_instr   = 8'h00;
      e_imm     = 8'h00;
      e_next    = m_pc;
      pend_next = edge_now;
      m_vsel    = 1;
      m_vec     = 1;
    end else if (d[7:4] == 4'hC) begin
      m_op    = d;
      m_pc    = m_pc + 8'd1;
      m_half  = 1;
      e_valid = 0;
    end else begin
      emit(d, 8'h00);
    end
    m_pend = pend_next;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check the combinational address, advance, check registers.
  task automatic step(input bit r, input bit s, input bit re,
                      input logic [7:0] rp, input bit is);
    rstn            = r;
    bus.stall       = s;
    bus.redirect_en = re;
    bus.redirect_pc = rp;
    bus.int_sig     = is;
    #1;
    if (m_init) check("imem_addr", bus.imem_addr, model_addr());
    model_clock(r, s, re, rp, is);
    @(posedge clk);
    #1;
    check("pc",         bus.pc,               m_pc);
    check("if_valid",   {7'd0, bus.if_valid}, {7'd0, e_valid});
    check("if_int",     {7'd0, bus.if_int},   {7'd0, e_int});
    check("if_instr",   bus.if_instr,         e_instr);
    check("if_imm",     bus.if_imm,           e_imm);
    check("if_pc_next", bus.if_pc_next,       e_next);
  endtask

  task automatic idle();
    step(1, 0, 0, 8'h00, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);
  endtask

  task automatic fill_mem();
    for (int unsigned i = 0; i < 256; i++) begin
      mem[i] = $urandom_range(0, 3) == 0 ? {4'hC, 4'($urandom)} : 8'($urandom);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_init = 0;
    rstn = 1'b0;
    bus.stall = 1'b0;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = '0;
    bus.int_sig = 1'b0;
    fill_mem();
    @(posedge clk);
    #1;

    // Reset vector then a 1-byte op
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h40; mem[8'h10] = 8'h21;
    do_reset();
    check("rst_valid", {7'd0, bus.if_valid}, 8'h00);
    check("rst_pc", bus.pc, 8'h00);
    idle();
    check("vec_pc", bus.pc, 8'h10);
    idle();
    check("op1_instr", bus.if_instr, 8'h21);
    check("op1_next", bus.if_pc_next, 8'h11);

    // 2-byte op followed by 1-byte op
    mem[8'h10] = 8'hC0; mem[8'h11] = 8'h20; mem[8'h12] = 8'hB4; mem[8'h13] = 8'h05;
    do_reset();
    idle();
    idle();
    check("op2_gap", {7'd0, bus.if_valid}, 8'h00);
    idle();
    check("op2_instr", bus.if_instr, 8'hC0);
    check("op2_imm", bus.if_imm, 8'h20);
    check("op2_next", bus.if_pc_next, 8'h12);
    idle();
    check("op3_instr", bus.if_instr, 8'hB4);
    check("op3_next", bus.if_pc_next, 8'h13);

    // Stall while waiting for the immediate
    do_reset();
    idle();
    idle();
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, 8'h00, 0);
      check("stall_pc", bus.pc, 8'h11);
    end
    idle();
    check("stall_rel", bus.if_instr, 8'hC0);
    idle();
    check("stall_once", bus.if_instr, 8'hB4);

    // Redirect during the immediate fetch drops the held opcode
    mem[8'h00] = 8'h20; mem[8'h20] = 8'hC1; mem[8'h30] = 8'hC2; mem[8'h31] = 8'h02;
    do_reset();
    idle();
    idle();
    step(1, 0, 1, 8'h30, 0);
    check("redir_pc", bus.pc, 8'h30);
    check("redir_valid", {7'd0, bus.if_valid}, 8'h00);
    idle();
    idle();
    check("redir_instr", bus.if_instr, 8'hC2);
    check("redir_imm", bus.if_imm, 8'h02);

    // Redirect wins over stall
    do_reset();
    idle();
    step(1, 1, 1, 8'h30, 0);
    check("redir_stall_pc", bus.pc, 8'h30);

    // Interrupt waits for the instruction boundary
    mem[8'h00] = 8'h10; mem[8'h10] = 8'hC0; mem[8'h11] = 8'h20; mem[8'h12] = 8'hB4;
    do_reset();
    idle();
    step(1, 0, 0, 8'h00, 1);
    idle();
    check("int_op_first", bus.if_instr, 8'hC0);
    idle();
    check("int_slot", {7'd0, bus.if_int}, 8'h01);
    check("int_instr", bus.if_instr, 8'h00);
    check("int_next", bus.if_pc_next, 8'h12);
    idle();
    check("int_vec_pc", bus.pc, 8'h40);

    // PC wrap at 0xFF
    mem[8'h00] = 8'hFF; mem[8'hFF] = 8'h05;
    do_reset();
    idle();
    idle();
    check("wrap_next", bus.if_pc_next, 8'h00);
    check("wrap_pc", bus.pc, 8'h00);

    // Random traffic against the model
    fill_mem();
    do_reset();
    begin
      bit is;
      is = 0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 19) == 0) is = ~is;
        step($urandom_range(0, 99) != 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 9) == 0,
             8'($urandom),
             is);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
